// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: produces a clean one-cycle `step` pulse for the LED pattern FSM.
// Manual mode: a 2-flop synchronised, debounced pushbutton. Auto mode: a
// programmable period timer. `step_cnt` counts issued steps modulo 256.
// Optional feature macro: BTN_STEP_CTRL_REPEAT_EN (hold-to-repeat in HELD).
module btn_step_ctrl #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       auto_en,
  input  logic [7:0] period,
  output logic       step,
  output logic [7:0] step_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDeb  = 2'd1,
    StHeld = 2'd2,
    StAuto = 2'd3
  } state_e;

  localparam logic [7:0] DebTarget = 8'(DEB_CYCLES);

  logic       sync1_q, sync2_q;
  logic       btn_s;
  state_e     state_q, state_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [7:0] per_cnt_q, per_cnt_d;
  logic       step_q, step_d;
  logic [7:0] step_cnt_q, step_cnt_d;

`ifdef BTN_STEP_CTRL_REPEAT_EN
  localparam logic [15:0] RepLast = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_cnt_q, rep_cnt_d;
`else
  // Repeat logic is compiled out; the parameter is intentionally unused.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
`endif

  assign btn_s = sync2_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and step decision; auto_en overrides button activity.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    per_cnt_d = per_cnt_q;
    step_d    = 1'b0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif

    if (auto_en && (state_q != StAuto)) begin
      state_d   = StAuto;
      deb_cnt_d = 8'd0;
      per_cnt_d = 8'd0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
      rep_cnt_d = 16'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_d   = StDeb;
            deb_cnt_d = 8'd1;
          end
        end

        StDeb: begin
          if (!btn_s) begin
            state_d   = StIdle;
            deb_cnt_d = 8'd0;
          end else if (deb_cnt_q >= DebTarget) begin
            step_d    = 1'b1;
            state_d   = StHeld;
            deb_cnt_d = 8'd0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
            rep_cnt_d = 16'd0;
`endif
          end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
          end
        end

        StHeld: begin
          if (btn_s) begin
            // Any high sample restarts the release count.
            deb_cnt_d = 8'd0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
            if (rep_cnt_q >= RepLast) begin
              step_d    = 1'b1;
              rep_cnt_d = 16'd0;
            end else begin
              rep_cnt_d = rep_cnt_q + 16'd1;
            end
`endif
          end else begin
`ifdef BTN_STEP_CTRL_REPEAT_EN
            rep_cnt_d = 16'd0;
`endif
            if ((deb_cnt_q + 8'd1) >= DebTarget) begin
              state_d   = StIdle;
              deb_cnt_d = 8'd0;
            end else begin
              deb_cnt_d = deb_cnt_q + 8'd1;
            end
          end
        end

        StAuto: begin
          if (!auto_en) begin
            state_d   = StIdle;
            deb_cnt_d = 8'd0;
            per_cnt_d = 8'd0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
            rep_cnt_d = 16'd0;
`endif
          end else if (period == 8'd0) begin
            // Paused: hold the timer at zero.
            per_cnt_d = 8'd0;
          end else if (per_cnt_q >= (period - 8'd1)) begin
            // >= so a live period reduction fires on the next cycle.
            step_d    = 1'b1;
            per_cnt_d = 8'd0;
          end else begin
            per_cnt_d = per_cnt_q + 8'd1;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    step_cnt_d = step_cnt_q + {7'd0, step_d};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      deb_cnt_q  <= 8'd0;
      per_cnt_q  <= 8'd0;
      step_q     <= 1'b0;
      step_cnt_q <= 8'd0;
`ifdef BTN_STEP_CTRL_REPEAT_EN
      rep_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      per_cnt_q  <= per_cnt_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
`ifdef BTN_STEP_CTRL_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign step     = step_q;
  assign step_cnt = step_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Self-checking bench for btn_step_ctrl. Expected step pulses (cycle, count)
// are queued as stimulus is driven and popped when the DUT pulses `step`.
module tb_btn_step_ctrl;

  localparam int unsigned Deb = 4;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       auto_en;
  logic [7:0] period;
  logic       step;
  logic [7:0] step_cnt;
  logic [1:0] state;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } sb_item_t;

  sb_item_t   exp_q[$];
  sb_item_t   mon_item;
  logic [7:0] exp_cnt;
  int         cyc;
  int         n_checks;
  int         n_fail;

  btn_step_ctrl #(
    .DEB_CYCLES   (Deb),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .auto_en (auto_en),
    .period  (period),
    .step    (step),
    .step_cnt(step_cnt),
    .state   (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_step(input int at);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{cyc: at, cnt: exp_cnt});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every pulse must match the queue front; stale fronts are misses.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_step", {31'd0, step}, 32'd1);
        void'(exp_q.pop_front());
      end
      if (step) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", {31'd0, step}, 32'd0);
        end else begin
          mon_item = exp_q.pop_front();
          check("step_cyc", 32'(cyc), 32'(mon_item.cyc));
          check("step_cnt", 32'(step_cnt), 32'(mon_item.cnt));
        end
      end
    end
  end

  initial begin
    int c;
    int n;
    logic [7:0] rep_exp;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 8'd0;
    reset    = 1'b0;
    btn_raw  = 1'b1;
    auto_en  = 1'b1;
    period   = 8'd0;

    // Reset held with button and auto both active.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_step", {31'd0, step}, 32'd0);
      check("rst_cnt", 32'(step_cnt), 32'd0);
      check("rst_state", 32'(state), 32'd0);
    end
    reset   = 1'b1;
    btn_raw = 1'b0;
    tick(1);
    check("post_rst_auto", 32'(state), 32'd3);
    auto_en = 1'b0;
    tick(1);
    check("post_rst_idle", 32'(state), 32'd0);
    tick(5);

    // Clean press: step after edge Deb+2, states 0->1->2->0.
    c = cyc;
    btn_raw = 1'b1;
    push_step(c + 1 + int'(Deb) + 2);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) btn_raw = 1'b0;
      if (i == 2)  check("press_idle", 32'(state), 32'd0);
      if (i == 3)  check("press_deb", 32'(state), 32'd1);
      if (i == 6)  check("press_deb_end", 32'(state), 32'd1);
      if (i == 7)  check("press_held", 32'(state), 32'd2);
      if (i == 25) check("press_held_rel", 32'(state), 32'd2);
      if (i == 26) check("press_idle_rel", 32'(state), 32'd0);
    end
    check("press_cnt", 32'(step_cnt), 32'd1);

    // Bounce: 3 high, 1 low, 2 high, then low -> no step.
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(1);
    btn_raw = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    tick(15);
    check("bounce_cnt", 32'(step_cnt), 32'd1);
    check("bounce_state", 32'(state), 32'd0);

    // Reset mid-debounce aborts, no step later.
    btn_raw = 1'b1;
    tick(4);
    #2 reset = 1'b0;
    exp_cnt = 8'd0;
    #1;
    check("deb_rst_state", 32'(state), 32'd0);
    check("deb_rst_cnt", 32'(step_cnt), 32'd0);
    @(negedge clk) btn_raw = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(15);
    check("deb_rst_after", 32'(step_cnt), 32'd0);

    // Reset mid-pulse clears step immediately.
    c = cyc;
    btn_raw = 1'b1;
    push_step(c + 1 + int'(Deb) + 2);
    tick(int'(Deb) + 3);
    #2 reset = 1'b0;
    exp_cnt = 8'd0;
    #1;
    check("pulse_rst_step", {31'd0, step}, 32'd0);
    check("pulse_rst_cnt", 32'(step_cnt), 32'd0);
    @(negedge clk) btn_raw = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(15);
    check("pulse_rst_after", 32'(step_cnt), 32'd0);

    // Auto mode, period 5: first step 5 cycles after entry edge.
    c = cyc;
    auto_en = 1'b1;
    period  = 8'd5;
    for (int k = 1; k <= 6; k++) push_step(c + 1 + 5 * k);
    tick(1);
    check("auto_state", 32'(state), 32'd3);
    tick(30);
    period = 8'd0;
    tick(20);
    check("auto_cnt", 32'(step_cnt), 32'd6);

    // Wrap: period=1 up to 255, then one more step -> 0.
    c = cyc;
    n = 255 - int'(exp_cnt);
    period = 8'd1;
    for (int k = 1; k <= n; k++) push_step(c + k);
    tick(n);
    period = 8'd0;
    tick(3);
    check("wrap_pre", 32'(step_cnt), 32'd255);
    c = cyc;
    period = 8'd1;
    push_step(c + 1);
    tick(1);
    period = 8'd0;
    tick(3);
    check("wrap_zero", 32'(step_cnt), 32'd0);

    // Button pressed during auto adds nothing.
    c = cyc;
    period  = 8'd7;
    btn_raw = 1'b1;
    for (int k = 1; k <= 3; k++) push_step(c + 7 * k);
    tick(21);
    period  = 8'd0;
    btn_raw = 1'b0;
    tick(10);
    check("auto_btn_state", 32'(state), 32'd3);
    check("auto_btn_cnt", 32'(step_cnt), 32'd3);
    auto_en = 1'b0;
    tick(1);
    check("auto_exit", 32'(state), 32'd0);

    // Long hold: repeat steps only when the feature is compiled in.
    @(negedge clk) reset = 1'b0;
    exp_cnt = 8'd0;
    tick(2);
    reset = 1'b1;
    tick(3);
    c = cyc;
    btn_raw = 1'b1;
    push_step(c + 1 + int'(Deb) + 2);
`ifdef BTN_STEP_CTRL_REPEAT_EN
    push_step(c + 23);
    push_step(c + 39);
    push_step(c + 55);
    rep_exp = 8'd4;
`else
    rep_exp = 8'd1;
`endif
    tick(60);
    btn_raw = 1'b0;
    tick(20);
    check("hold_cnt", 32'(step_cnt), 32'(rep_exp));
    check("hold_idle", 32'(state), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
